// File: rtl/rle_uart_packer_pkg.sv
// Shared types and constants for the RLE-to-UART frame packer.
// Optional checksum state is only reachable when RLE_UART_PACKER_CHECKSUM_EN is defined.
package rle_uart_packer_pkg;

  localparam int unsigned PairWidth      = 16;
  localparam logic [7:0]  SofByteDefault = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StSof,
    StVal,
    StCnt,
    StWait,
    StChk
  } pack_state_e;

  typedef struct packed {
    logic [7:0] value;
    logic [7:0] count;
  } rle_pair_t;

endpackage

// File: rtl/rle_uart_packer_if.sv
// RLE pair input and UART byte output bundle for rle_uart_packer.
// slave is the packer side; master is the surrounding environment.
interface rle_uart_packer_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic              i_pair_ready;
  logic [7:0]        i_val;
  logic [7:0]        i_count;
  logic              i_tx_ready;
  logic [7:0]        o_byte;
  logic              o_byte_valid;
  logic              o_frame_done;
  logic              o_overflow;
  logic [LevelW-1:0] o_fifo_level;

  modport master (
    output i_pair_ready, i_val, i_count, i_tx_ready,
    input  o_byte, o_byte_valid, o_frame_done, o_overflow, o_fifo_level
  );

  modport slave (
    input  i_pair_ready, i_val, i_count, i_tx_ready,
    output o_byte, o_byte_valid, o_frame_done, o_overflow, o_fifo_level
  );

endinterface

// File: rtl/rle_pair_fifo.sv
// Synchronous FIFO for RLE pairs; pointers carry one extra wrap bit.
// A write is accepted while full only when a read happens in the same cycle.
module rle_pair_fifo #(
  parameter int unsigned  DEPTH = 8,
  parameter int unsigned  WIDTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/rle_uart_packer.sv
// Buffers RLE value/count pairs and serialises them as SOF, value/count bytes per frame.
// Define RLE_UART_PACKER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module rle_uart_packer
  import rle_uart_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FRAME_PAIRS = 16,
  parameter logic [7:0]  SOF_BYTE    = SofByteDefault
) (
  input logic              CLK,
  input logic              RST,
  rle_uart_packer_if.slave bus
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  pack_state_e          state_q, state_d;
  logic                 prev_ready_q, overflow_q, overflow_d;
  logic                 valid_q, valid_d, done_q, done_d;
  logic [7:0]           byte_q, byte_d, count_q, count_d, pair_cnt_q, pair_cnt_d;
  logic                 pair_stb, pop, accept, last_pair;
  logic                 fifo_full, fifo_empty;
  logic [PairWidth-1:0] fifo_head_raw;
  rle_pair_t            fifo_head;
  logic [LevelW-1:0]    fifo_level;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  assign pair_stb   = bus.i_pair_ready & ~prev_ready_q;
  assign accept     = valid_q & bus.i_tx_ready;
  assign last_pair  = (32'(pair_cnt_q) + 32'd1) == FRAME_PAIRS;
  assign fifo_head  = rle_pair_t'(fifo_head_raw);
  assign overflow_d = overflow_q | (pair_stb & fifo_full & ~pop);

  rle_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PairWidth)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en_i   (pair_stb),
    .wr_data_i ({bus.i_val, bus.i_count}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head_raw),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (!fifo_empty) state_d = StSof;
      StSof:  if (accept) state_d = StVal;
      StVal:  if (accept) state_d = StCnt;
      StCnt: begin
        if (accept) begin
          if (last_pair) begin
`ifdef RLE_UART_PACKER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StIdle;
`endif
          end else if (!fifo_empty) begin
            state_d = StVal;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: if (!fifo_empty) state_d = StVal;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
      StChk:  if (accept) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output bytes are registered; these are the values loaded on the next edge.
  always_comb begin
    byte_d     = byte_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    count_d    = count_q;
    pair_cnt_d = pair_cnt_q;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          byte_d  = SOF_BYTE;
          valid_d = 1'b1;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StSof: begin
        if (accept) begin
          pop     = 1'b1;
          byte_d  = fifo_head.value;
          count_d = fifo_head.count;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
          csum_d  = csum_q ^ fifo_head.value;
`endif
        end
      end
      StVal: begin
        if (accept) begin
          byte_d = count_q;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
          csum_d = csum_q ^ count_q;
`endif
        end
      end
      StCnt: begin
        if (accept) begin
          if (last_pair) begin
            pair_cnt_d = '0;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
            byte_d     = csum_q;
`else
            valid_d    = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            pair_cnt_d = pair_cnt_q + 8'd1;
            if (!fifo_empty) begin
              pop     = 1'b1;
              byte_d  = fifo_head.value;
              count_d = fifo_head.count;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
              csum_d  = csum_q ^ fifo_head.value;
`endif
            end else begin
              valid_d = 1'b0;
            end
          end
        end
      end
      StWait: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          byte_d  = fifo_head.value;
          valid_d = 1'b1;
          count_d = fifo_head.count;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
          csum_d  = csum_q ^ fifo_head.value;
`endif
        end
      end
`ifdef RLE_UART_PACKER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      byte_q       <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      pair_cnt_q   <= '0;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      prev_ready_q <= bus.i_pair_ready;
      overflow_q   <= overflow_d;
      byte_q       <= byte_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      count_q      <= count_d;
      pair_cnt_q   <= pair_cnt_d;
`ifdef RLE_UART_PACKER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.o_byte       = byte_q;
  assign bus.o_byte_valid = valid_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_fifo_level = fifo_level;

endmodule

// File: tb/tb_rle_uart_packer.sv
// Two packers (A: depth 4, 2 pairs/frame; B: depth 8, 1 pair/frame) share stimulus and are
// checked against a byte-stream reference model. Honours RLE_UART_PACKER_CHECKSUM_EN.
module tb_rle_uart_packer;

  logic       clk;
  logic       rst;
  logic       pair_ready;
  logic [7:0] val;
  logic [7:0] count;
  logic       tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  rle_uart_packer_if #(.FIFO_DEPTH(4)) if_a ();
  rle_uart_packer_if #(.FIFO_DEPTH(8)) if_b ();

  assign if_a.i_pair_ready = pair_ready;
  assign if_a.i_val        = val;
  assign if_a.i_count      = count;
  assign if_a.i_tx_ready   = tx_ready;
  assign if_b.i_pair_ready = pair_ready;
  assign if_b.i_val        = val;
  assign if_b.i_count      = count;
  assign if_b.i_tx_ready   = tx_ready;

  rle_uart_packer #(.FIFO_DEPTH(4), .FRAME_PAIRS(2), .SOF_BYTE(8'hA5)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (if_a)
  );

  rle_uart_packer #(.FIFO_DEPTH(8), .FRAME_PAIRS(1), .SOF_BYTE(8'hA5)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected byte stream per packer, with end-of-frame markers.
  logic [7:0] exp_a[$], exp_b[$];
  bit         last_a[$], last_b[$];
  int         fcnt[2];
  logic [7:0] fxor[2];
  bit         done_pend[2];
  bit         hold_v[2];
  logic [7:0] hold_b[2];
  int         acc[2];

`ifdef RLE_UART_PACKER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic q_push(input int d, input logic [7:0] b, input bit last);
    if (d == 0) begin exp_a.push_back(b); last_a.push_back(last); end
    else        begin exp_b.push_back(b); last_b.push_back(last); end
  endtask

  task automatic model_push(input int d, input logic [7:0] v, input logic [7:0] c);
    int fp;
    fp = (d == 0) ? 2 : 1;
    if (fcnt[d] == 0) begin
      q_push(d, 8'hA5, 1'b0);
      fxor[d] = 8'h00;
    end
    q_push(d, v, 1'b0);
    fxor[d] = fxor[d] ^ v ^ c;
    fcnt[d]++;
    q_push(d, c, (fcnt[d] == fp) && !CsumEn);
    if (fcnt[d] == fp) begin
      if (CsumEn) q_push(d, fxor[d], 1'b1);
      fcnt[d] = 0;
    end
  endtask

  task automatic model_clear();
    exp_a.delete(); exp_b.delete(); last_a.delete(); last_b.delete();
    for (int d = 0; d < 2; d++) begin
      fcnt[d] = 0; fxor[d] = 8'h00; done_pend[d] = 1'b0; hold_v[d] = 1'b0;
    end
  endtask

  task automatic mon(input int d);
    logic [7:0] ob, e;
    logic       ov, od;
    bit         l;
    string      nm;
    nm = (d == 0) ? "a" : "b";
    if (d == 0) begin ob = if_a.o_byte; ov = if_a.o_byte_valid; od = if_a.o_frame_done; end
    else        begin ob = if_b.o_byte; ov = if_b.o_byte_valid; od = if_b.o_frame_done; end
    check({nm, ":frame_done"}, 32'(od), 32'(done_pend[d]));
    if (hold_v[d]) begin
      check({nm, ":hold_valid"}, 32'(ov), 32'd1);
      check({nm, ":hold_byte"}, 32'(ob), 32'(hold_b[d]));
    end
    hold_v[d]    = ov && !tx_ready;
    hold_b[d]    = ob;
    done_pend[d] = 1'b0;
    if (ov && tx_ready) begin
      acc[d]++;
      if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
        check({nm, ":unexpected_byte_valid"}, 32'(ov), 32'd0);
      end else begin
        if (d == 0) begin e = exp_a.pop_front(); l = last_a.pop_front(); end
        else        begin e = exp_b.pop_front(); l = last_b.pop_front(); end
        check({nm, ":byte"}, 32'(ob), 32'(e));
        done_pend[d] = l;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      mon(0);
      mon(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero();
    check("a:rst_byte", 32'(if_a.o_byte), 32'd0);
    check("a:rst_valid", 32'(if_a.o_byte_valid), 32'd0);
    check("a:rst_done", 32'(if_a.o_frame_done), 32'd0);
    check("a:rst_ovf", 32'(if_a.o_overflow), 32'd0);
    check("a:rst_level", 32'(if_a.o_fifo_level), 32'd0);
    check("b:rst_byte", 32'(if_b.o_byte), 32'd0);
    check("b:rst_valid", 32'(if_b.o_byte_valid), 32'd0);
    check("b:rst_level", 32'(if_b.o_fifo_level), 32'd0);
  endtask

  task automatic apply_reset();
    pair_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_zero();
    model_clear();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] v, input logic [7:0] c, input bit to_a,
                           input bit to_b);
    val = v;
    count = c;
    pair_ready = 1'b1;
    if (to_a) model_push(0, v, c);
    if (to_b) model_push(1, v, c);
    cycle();
    pair_ready = 1'b0;
    cycle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || done_pend[0] || done_pend[1]) &&
           n < budget) begin
      cycle();
      n++;
    end
    check("a:drain_left", 32'(exp_a.size()), 32'd0);
    check("b:drain_left", 32'(exp_b.size()), 32'd0);
    repeat (6) cycle();
  endtask

  initial begin
    int peak;
    int base;
    int n;
    tx_ready = 1'b0;
    val = 8'h00;
    count = 8'h00;
    for (int d = 0; d < 2; d++) acc[d] = 0;
    apply_reset();

    // Single pair under backpressure with the pair level held for 20 cycles.
    tx_ready = 1'b0;
    val = 8'h10;
    count = 8'd3;
    pair_ready = 1'b1;
    model_push(0, 8'h10, 8'd3);
    model_push(1, 8'h10, 8'd3);
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (int'(if_a.o_fifo_level) > peak) peak = int'(if_a.o_fifo_level);
    end
    check("a:level_peak", 32'(peak), 32'd1);
    check("b:level_held", 32'(if_b.o_fifo_level), 32'd1);
    check("a:bp_sof", 32'(if_a.o_byte), 32'hA5);
    check("b:bp_valid", 32'(if_b.o_byte_valid), 32'd1);
    pair_ready = 1'b0;
    drain(100);

    // Packer A is now mid-frame with an empty FIFO: output must stay idle.
    for (int i = 0; i < 50; i++) begin
      cycle();
      check("a:stall_valid", 32'(if_a.o_byte_valid), 32'd0);
    end
    send_pair(8'h5C, 8'd200, 1'b1, 1'b1);
    drain(100);

    // Randomised traffic, throttled so neither FIFO can overflow.
    for (int i = 0; i < 1500; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (pair_ready) begin
        pair_ready = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 2) == 0 && exp_a.size() <= 6 && exp_b.size() <= 14) begin
        val = 8'($urandom);
        count = 8'($urandom_range(1, 255));
        pair_ready = 1'b1;
        model_push(0, val, count);
        model_push(1, val, count);
      end
      cycle();
    end
    pair_ready = 1'b0;
    drain(400);

    // Overflow: five strobes with the UART stalled.
    apply_reset();
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_pair(8'(8'h40 + k), 8'(k + 1), (k < 4), 1'b1);
    end
    check("a:ovf", 32'(if_a.o_overflow), 32'd1);
    check("a:ovf_level", 32'(if_a.o_fifo_level), 32'd4);
    check("b:no_ovf", 32'(if_b.o_overflow), 32'd0);
    check("b:level5", 32'(if_b.o_fifo_level), 32'd5);
    drain(200);
    check("a:ovf_sticky", 32'(if_a.o_overflow), 32'd1);

    // Reset in the middle of a frame, right after the value byte is accepted.
    apply_reset();
    tx_ready = 1'b1;
    base = acc[0];
    val = 8'h77;
    count = 8'd9;
    pair_ready = 1'b1;
    model_push(0, 8'h77, 8'd9);
    model_push(1, 8'h77, 8'd9);
    cycle();
    pair_ready = 1'b0;
    n = 0;
    while (acc[0] < base + 2 && n < 40) begin
      cycle();
      n++;
    end
    check("a:val_accepted", 32'(acc[0] - base), 32'd2);
    apply_reset();
    send_pair(8'h22, 8'd5, 1'b1, 1'b1);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
